serial_link_cfg_responder: RTL
==============================

Name: serial_link_cfg_responder

Overview:
Register-bus responder (RegBus slave) that holds the serial link's control and status registers. These are the CTRL, ISOLATED, CHANNEL_ALLOC_TX_CFG, CHANNEL_ALLOC_RX_CFG and STATUS registers.
- It drives clock-gate, link-reset, AXI-isolation and channel-allocator config outputs toward the link datapath.
- It samples isolation status back from the datapath.
- A watchdog flags isolation requests that are not acknowledged in time.
- It sits between the SoC config crossbar and the serial link core, in the clk_1 domain.

Parameters:
- AddrWidth, 32, RegBus address width.
- DataWidth, 32, RegBus data width; fixed at 32 (elaboration assertion).
- IsoTimeout, 1024, cycles allowed between an isolation-request change and a matching isolated_i; range 2..65535.

Ports:
- clk_1  in  1  block clock.
- rst_1_n  in  1  reset.
- reg_valid_i  in  1  request valid.
- reg_write_i  in  1  1 = write, 0 = read.
- reg_addr_i  in  AddrWidth  byte address; only [4:0] decoded, upper bits must be 0.
- reg_wdata_i  in  32  write data.
- reg_wstrb_i  in  4  byte strobes.
- reg_rdata_o  out  32  read data.
- reg_error_o  out  1  access error.
- reg_ready_o  out  1  response valid.
- clk_ena_o  out  1  link clock enable (CTRL[0]).
- link_rst_o  out  1  link reset control (CTRL[1]).
- axi_in_iso_o  out  1  isolate AXI slave port (CTRL[8]).
- axi_out_iso_o  out  1  isolate AXI master port (CTRL[9]).
- isolated_i  in  2  [0] in-port isolated, [1] out-port isolated.
- tx_cfg_o  out  16  CHANNEL_ALLOC_TX_CFG[15:0].
- rx_cfg_o  out  16  CHANNEL_ALLOC_RX_CFG[15:0].

Interface: reset rst_1_n, asynchronous, active-high; clock clk_1.

Behaviour:
- Register map, offsets in bytes:
  - 0x00 CTRL: RW, implemented bits [9:8], [1:0], reset 0x300.
  - 0x04 ISOLATED: RO = {30'b0, isolated_q}, where isolated_q is isolated_i registered once.
  - 0x08 TX_CFG: RW, bits [15:0], reset 0x0000. Bit0 = bypass, bit1 = auto_flush, [15:8] = flush count.
  - 0x0C RX_CFG: RW, bits [15:0], reset 0x0000. Bit0 = bypass, bit1 = auto_flush, bit2 = sync_en.
  - 0x10 STATUS: bit0 iso_timeout, W1C. Bits [31:16] hold the watchdog count, RO.
- Unimplemented bits read 0 and ignore writes.
- Write strobes apply per byte. wstrb = 0 is a legal no-op write.
- FSM has two states, IDLE and RESP. Reset state is IDLE.
  - IDLE with reg_valid_i: decode and perform the access in this cycle (register update at the clock edge), capture rdata/error, go to RESP.
  - RESP: reg_ready_o = 1, then unconditionally return to IDLE.
  - Latency is 1 cycle from the accepting edge to ready. Back-to-back accesses occur every 2 cycles.
  - The master holds the request until ready. A request present in IDLE after RESP is treated as new.
- Error (reg_error_o = 1 in RESP, no state change):
  - address not in the map;
  - address not 4-byte aligned;
  - address upper bits nonzero;
  - write to 0x04.
  - Writes to 0x10 bits other than bit0 are ignored, not an error.
- Read data is 0 on error and for writes.
- Watchdog:
  - Mismatch = {axi_out_iso_o, axi_in_iso_o} != isolated_q.
  - While mismatched, the 16-bit counter increments, saturating at 0xFFFF.
  - With no mismatch, the counter clears to 0.
  - When the counter equals IsoTimeout-1 and mismatch holds, set iso_timeout (sticky).
  - On a W1C in the same cycle as a set event, the set wins.
  - A CTRL write changing an iso bit restarts the counter at 0 on the next edge.
- Reset values, all while reset is asserted, including mid-transaction: FSM IDLE, reg_ready_o 0, reg_error_o 0, reg_rdata_o 0, CTRL 0x300 (clk_ena_o 0, link_rst_o 0, both iso outputs 1), tx/rx cfg 0, isolated_q 0, counter 0, iso_timeout 0.
  - A transaction in flight at reset is dropped, with no ready.
- All outputs are driven directly from flops (no combinational path from reg inputs to link outputs).

Decomposition:
- Package serial_link_cfg_pkg holds:
  - offset constants CTRL_OFFSET = 0x00, ISOLATED_OFFSET = 0x04, TX_CFG_OFFSET = 0x08, RX_CFG_OFFSET = 0x0C, STATUS_OFFSET = 0x10;
  - CTRL_RESET = 0x300;
  - the FSM state enum;
  - packed structs ctrl_reg_t and alloc_cfg_t.
- One sub-module is natural: serial_link_iso_watchdog, which contains the counter, mismatch compare and sticky flag, with a clear input and a restart input.

Test Plan:
- Reset, then read 0x00 -> rdata 0x300, ready 1 cycle after accept, error 0; axi_in_iso_o = axi_out_iso_o = 1, clk_ena_o = 0.
- Write CTRL 0x300, 0x302, 0x303 in turn -> link_rst_o becomes 1, then clk_ena_o becomes 1. Write TX_CFG and RX_CFG with 0x3 -> tx_cfg_o = rx_cfg_o = 0x0003. Write CTRL 0x03 -> both iso outputs 0.
- Write 0x12345678 to TX_CFG with wstrb 0b0010 -> tx_cfg_o = 0x5600; read back 0x00005600.
- Write 0x04, read 0x14, read 0x03 -> each returns error 1 with rdata 0, and no register changes.
- Clear both iso bits with isolated_i held at 2'b11 and IsoTimeout = 16 -> STATUS bit0 sets after 16 cycles. Drive isolated_i = 0 -> counter reads 0. W1C 0x1 -> bit0 clears. W1C on the set cycle -> bit0 stays 1.
- Assert reset during RESP -> reg_ready_o 0 and all registers at reset values; the next read of 0x00 returns 0x300.

Source files
------------

// File: rtl/serial_link_cfg_pkg.sv
// Shared register map, reset values and field layouts for the serial link
// configuration responder.
package serial_link_cfg_pkg;

    localparam logic [4:0] CTRL_OFFSET     = 5'h00;
    localparam logic [4:0] ISOLATED_OFFSET = 5'h04;
    localparam logic [4:0] TX_CFG_OFFSET   = 5'h08;
    localparam logic [4:0] RX_CFG_OFFSET   = 5'h0C;
    localparam logic [4:0] STATUS_OFFSET   = 5'h10;

    localparam logic [31:0] CTRL_RESET = 32'h0000_0300;

    typedef enum logic [0:0] {
        StIdle,
        StResp
    } state_e;

    typedef struct packed {
        logic axi_out_iso;
        logic axi_in_iso;
        logic link_rst;
        logic clk_ena;
    } ctrl_reg_t;

    typedef struct packed {
        logic [7:0] flush_count;
        logic [5:0] misc;
        logic       auto_flush;
        logic       bypass;
    } alloc_cfg_t;

    function automatic ctrl_reg_t ctrl_unpack(input logic [31:0] v);
        ctrl_reg_t c;
        c.axi_out_iso = v[9];
        c.axi_in_iso  = v[8];
        c.link_rst    = v[1];
        c.clk_ena     = v[0];
        return c;
    endfunction

    function automatic logic [31:0] ctrl_pack(input ctrl_reg_t c);
        return {22'b0, c.axi_out_iso, c.axi_in_iso, 6'b0, c.link_rst, c.clk_ena};
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/serial_link_iso_watchdog.sv
// Counts cycles during which the requested isolation state disagrees with the
// sampled datapath status and raises a sticky timeout flag.
module serial_link_iso_watchdog #(
    parameter int unsigned IsoTimeout = 1024
) (
    input  logic        clk_1,
    input  logic        rst_1_n,
    input  logic [1:0]  iso_req,
    input  logic [1:0]  isolated,
    input  logic        restart,
    input  logic        clear,
    output logic        timeout,
    output logic [15:0] count
);

    if (IsoTimeout < 2 || IsoTimeout > 65535) begin : gen_timeout_check
        $error("IsoTimeout must be within 2..65535");
    end

    localparam logic [15:0] FireCount = 16'(IsoTimeout - 1);

    logic [15:0] count_q, count_d;
    logic        timeout_q, timeout_d;
    logic        mismatch, set_evt;

    always_comb begin
        mismatch = iso_req != isolated;
        set_evt  = mismatch && (count_q == FireCount);
        count_d  = count_q;
        if (restart || !mismatch) begin
            count_d = '0;
        end else if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
        // A set event in the same cycle as a clear keeps the flag raised.
        timeout_d = set_evt | (timeout_q & ~clear);
    end

    always_ff @(posedge clk_1 or posedge rst_1_n) begin
        if (rst_1_n) begin
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
    assign count   = count_q;

endmodule

// File: rtl/serial_link_cfg_responder.sv
// RegBus responder holding the serial link CTRL, ISOLATED, channel allocator
// config and STATUS registers, with an isolation-handshake watchdog.
module serial_link_cfg_responder
    import serial_link_cfg_pkg::*;
#(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned IsoTimeout = 1024
) (
    input  logic                 clk_1,
    input  logic                 rst_1_n,
    input  logic                 reg_valid_i,
    input  logic                 reg_write_i,
    input  logic [AddrWidth-1:0] reg_addr_i,
    input  logic [31:0]          reg_wdata_i,
    input  logic [3:0]           reg_wstrb_i,
    output logic [31:0]          reg_rdata_o,
    output logic                 reg_error_o,
    output logic                 reg_ready_o,
    output logic                 clk_ena_o,
    output logic                 link_rst_o,
    output logic                 axi_in_iso_o,
    output logic                 axi_out_iso_o,
    input  logic [1:0]           isolated_i,
    output logic [15:0]          tx_cfg_o,
    output logic [15:0]          rx_cfg_o
);

    if (DataWidth != 32) begin : gen_data_width_check
        $error("DataWidth must be 32");
    end

    state_e      state_q;
    ctrl_reg_t   ctrl_q, ctrl_new;
    alloc_cfg_t  tx_q, rx_q, tx_new, rx_new;
    logic [1:0]  isolated_q;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, ready_q;

    logic [4:0]  offset;
    logic        upper_nz, acc_err, accept;
    logic        hit_ctrl, hit_iso, hit_tx, hit_rx, hit_status;
    logic        ctrl_wr, tx_wr, rx_wr, status_wr;
    logic        iso_restart, status_clear;
    logic [31:0] wmask;
    logic        wd_timeout;
    logic [15:0] wd_count;

    always_comb begin
        offset     = reg_addr_i[4:0];
        upper_nz   = |(reg_addr_i >> 5);
        hit_ctrl   = offset == CTRL_OFFSET;
        hit_iso    = offset == ISOLATED_OFFSET;
        hit_tx     = offset == TX_CFG_OFFSET;
        hit_rx     = offset == RX_CFG_OFFSET;
        hit_status = offset == STATUS_OFFSET;
        acc_err    = upper_nz || (offset[1:0] != 2'b00)
                     || !(hit_ctrl || hit_iso || hit_tx || hit_rx || hit_status)
                     || (reg_write_i && hit_iso);

        accept    = reg_valid_i && (state_q == StIdle);
        ctrl_wr   = accept && reg_write_i && !acc_err && hit_ctrl;
        tx_wr     = accept && reg_write_i && !acc_err && hit_tx;
        rx_wr     = accept && reg_write_i && !acc_err && hit_rx;
        status_wr = accept && reg_write_i && !acc_err && hit_status;

        wmask    = strb_mask(reg_wstrb_i);
        ctrl_new = ctrl_unpack((ctrl_pack(ctrl_q) & ~wmask) | (reg_wdata_i & wmask));
        tx_new   = alloc_cfg_t'((tx_q & ~wmask[15:0]) | (reg_wdata_i[15:0] & wmask[15:0]));
        rx_new   = alloc_cfg_t'((rx_q & ~wmask[15:0]) | (reg_wdata_i[15:0] & wmask[15:0]));

        iso_restart  = ctrl_wr && ({ctrl_new.axi_out_iso, ctrl_new.axi_in_iso}
                                   != {ctrl_q.axi_out_iso, ctrl_q.axi_in_iso});
        status_clear = status_wr && reg_wstrb_i[0] && reg_wdata_i[0];

        rdata_d = '0;
        if (!reg_write_i && !acc_err) begin
            if (hit_ctrl) begin
                rdata_d = ctrl_pack(ctrl_q);
            end else if (hit_iso) begin
                rdata_d = {30'b0, isolated_q};
            end else if (hit_tx) begin
                rdata_d = {16'b0, tx_q};
            end else if (hit_rx) begin
                rdata_d = {16'b0, rx_q};
            end else if (hit_status) begin
                rdata_d = {wd_count, 15'b0, wd_timeout};
            end
        end
    end

    always_ff @(posedge clk_1 or posedge rst_1_n) begin
        if (rst_1_n) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            rdata_q    <= '0;
            ctrl_q     <= ctrl_unpack(CTRL_RESET);
            tx_q       <= '0;
            rx_q       <= '0;
            isolated_q <= '0;
        end else begin
            isolated_q <= isolated_i;
            unique case (state_q)
                StIdle: begin
                    if (reg_valid_i) begin
                        state_q <= StResp;
                        ready_q <= 1'b1;
                        error_q <= acc_err;
                        rdata_q <= rdata_d;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                    error_q <= 1'b0;
                    rdata_q <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                end
            endcase
            if (ctrl_wr) ctrl_q <= ctrl_new;
            if (tx_wr)   tx_q   <= tx_new;
            if (rx_wr)   rx_q   <= rx_new;
        end
    end

    serial_link_iso_watchdog #(
        .IsoTimeout (IsoTimeout)
    ) u_iso_watchdog (
        .clk_1    (clk_1),
        .rst_1_n  (rst_1_n),
        .iso_req  ({ctrl_q.axi_out_iso, ctrl_q.axi_in_iso}),
        .isolated (isolated_q),
        .restart  (iso_restart),
        .clear    (status_clear),
        .timeout  (wd_timeout),
        .count    (wd_count)
    );

    assign reg_rdata_o   = rdata_q;
    assign reg_error_o   = error_q;
    assign reg_ready_o   = ready_q;
    assign clk_ena_o     = ctrl_q.clk_ena;
    assign link_rst_o    = ctrl_q.link_rst;
    assign axi_in_iso_o  = ctrl_q.axi_in_iso;
    assign axi_out_iso_o = ctrl_q.axi_out_iso;
    assign tx_cfg_o      = tx_q;
    assign rx_cfg_o      = rx_q;

endmodule
